// File: rtl/matmul_host_ctrl.sv
// Host-side sequencer for the 4x4 multiplier: loads A/B operands, starts the
// core, waits for done under a timeout and streams the N*N results out.
//
// state  | meaning
// IDLE   | ready for the first operand word of a new job
// LOAD   | accepting the remaining operand words
// START  | one-cycle start pulse to the multiplier
// WAIT   | waiting for done; timer running toward the abort limit
// RD_REQ | result address presented to the result memory
// RD_CAP | read data captured into the output register
// SEND   | result word held until the downstream accepts it
module matmul_host_ctrl #(
  parameter  int N       = 4,
  parameter  int DATA_W  = 8,
  parameter  int ACC_W   = 18,
  parameter  int TIMEOUT = 1024,
  localparam int NN      = N * N,
  localparam int WA      = $clog2(2 * NN),
  localparam int RA      = $clog2(NN),
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [WA-1:0]     mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mm_start,
  input  logic              mm_done,
  output logic [RA-1:0]     res_raddr,
  input  logic [ACC_W-1:0]  res_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RD_REQ = 3'd4,
    S_RD_CAP = 3'd5,
    S_SEND   = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WA-1:0]     r_wcnt;
  logic [RA-1:0]     r_rcnt;
  logic [TW-1:0]     r_timer;
  logic [RA-1:0]     r_raddr;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_data;
  logic              r_out_last;
  logic              r_timeout_err;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_wlast;
  logic              w_rlast;
  logic              w_tmo;

  // Gated by reset so a word presented during reset is never written.
  assign w_in_ready = !reset && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_accept   = in_valid && w_in_ready;
  assign w_wlast    = (r_wcnt == WA'(2 * NN - 1));
  assign w_rlast    = (r_rcnt == RA'(NN - 1));
  assign w_tmo      = (r_timer == TW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_LOAD;
      S_LOAD:   if (w_accept && w_wlast) w_next = S_START;
      S_START:  w_next = S_WAIT;
      S_WAIT: begin
        if (mm_done)    w_next = S_RD_REQ;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_RD_REQ: w_next = S_RD_CAP;
      S_RD_CAP: w_next = S_SEND;
      S_SEND: begin
        if (out_ready) w_next = w_rlast ? S_IDLE : S_RD_REQ;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      r_rcnt        <= '0;
      r_timer       <= '0;
      r_raddr       <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wcnt        <= WA'(1);
            r_timeout_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) r_wcnt <= w_wlast ? '0 : r_wcnt + WA'(1);
        end
        S_START: r_timer <= '0;
        S_WAIT: begin
          // done has priority over an expiring timer
          if (mm_done)    r_rcnt        <= '0;
          else if (w_tmo) r_timeout_err <= 1'b1;
          else            r_timer       <= r_timer + TW'(1);
        end
        S_RD_REQ: r_raddr <= r_rcnt;
        S_RD_CAP: begin
          r_out_data  <= res_rdata;
          r_out_valid <= 1'b1;
          r_out_last  <= w_rlast;
        end
        S_SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (!w_rlast) r_rcnt <= r_rcnt + RA'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign mem_we      = w_accept;
  assign mem_waddr   = (r_state == S_IDLE) ? '0 : r_wcnt;
  assign mem_wdata   = in_data;
  assign mm_start    = (r_state == S_START);
  // Address is live during RD_REQ and held from the register afterwards.
  assign res_raddr   = (r_state == S_RD_REQ) ? r_rcnt : r_raddr;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_matmul_host_ctrl.sv
// Bench for matmul_host_ctrl: emulates the multiplier core and its memories,
// drives a table of jobs plus random jobs, and checks results against plain matrix arithmetic.
module tb_matmul_host_ctrl;
  localparam int N  = 4;
  localparam int NN = N * N;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic        mm_start;
  logic        mm_done;
  logic [3:0]  res_raddr;
  logic [17:0] res_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic        out_last;
  logic        busy;
  logic        timeout_err;

  matmul_host_ctrl #(.N(N), .DATA_W(8), .ACC_W(18), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mm_start(mm_start), .mm_done(mm_done),
    .res_raddr(res_raddr), .res_rdata(res_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Multiplier core emulation: operand memory, result memory, done after done_lat cycles.
  logic [7:0]  opmem [2*NN];
  logic [17:0] cmem  [NN];
  int          cyc = 0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          done_cd = 0;
  int          done_lat;
  logic        spur_done;
  int          macc;

  assign mm_done = (done_cd == 1) || spur_done;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) opmem[mem_waddr] <= mem_wdata;
    res_rdata <= cmem[res_raddr];
    if (mm_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc + 1;
      done_cd   <= done_lat;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          macc = 0;
          for (int k = 0; k < N; k++)
            macc = macc + int'(opmem[i*N+k]) * int'(opmem[NN+k*N+j]);
          cmem[i*N+j] <= 18'(macc);
        end
    end else if (done_cd > 0) begin
      done_cd <= done_cd - 1;
    end
  end

  typedef struct {
    int a_kind;   // 0 identity, 1 sequence 1..16, 2 all 255, 3 random
    int b_kind;
    bit gaps;     // idle cycle before every word
    bit stall;    // 5-cycle backpressure on every other result
    bit spur;     // mm_done pulsed on gap cycles
    bit abort;    // reset while the first result waits in SEND
    int done_lat; // 0 = core never finishes
    bit exp_to;
    int exp_c0;   // -1 = checked by the arithmetic model only
    int exp_cl;
  } job_t;

  int n_cmp = 0;
  int n_bad = 0;
  bit prev_to = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gen_word(input int kind, input int idx);
    case (kind)
      0:       return ((idx / N) == (idx % N)) ? 1 : 0;
      1:       return idx + 1;
      2:       return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic run_job(input job_t j);
    int w[2*NN];
    int exp_c[NN];
    int s0, k, guard, stall_left;
    bit seen;
    longint lat_d, lat_l;

    for (int i = 0; i < NN; i++) begin
      w[i]      = gen_word(j.a_kind, i);
      w[NN + i] = gen_word(j.b_kind, i);
    end
    for (int i = 0; i < N; i++)
      for (int c = 0; c < N; c++) begin
        exp_c[i*N+c] = 0;
        for (int m = 0; m < N; m++) exp_c[i*N+c] += w[i*N+m] * w[NN+m*N+c];
      end

    done_lat = j.done_lat;
    s0 = start_cnt;

    for (int n = 0; n < 2*NN; n++) begin
      if (j.gaps) begin
        in_valid  = 1'b0;
        spur_done = j.spur;
        #1;
        chk("gap_no_we", mem_we, 0);
        @(posedge clk); #1;
        spur_done = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = 8'(w[n]);
      #1;
      chk("in_ready", in_ready, 1);
      chk("mem_we", mem_we, 1);
      chk("mem_waddr", mem_waddr, n);
      if (n == 0 && prev_to) chk("err_sticky", timeout_err, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (n == 0) chk("err_cleared", timeout_err, 0);
      if (n < 2*NN-1) begin
        chk("no_early_start", start_cnt - s0, 0);
        chk("busy_load", busy, 1);
      end
    end
    chk("start_pulse", mm_start, 1);
    chk("ready_low_start", in_ready, 0);
    @(posedge clk); #1;
    chk("start_single", mm_start, 0);

    if (j.exp_to) begin
      guard = 0;
      while (!timeout_err && guard < TO + 20) begin
        @(posedge clk); #1;
        guard++;
        chk("to_no_valid", out_valid, 0);
      end
      if (!timeout_err) begin
        n_cmp++; n_bad++;
        $display("FAIL to_flag: got no timeout_err after %0d cycles, expected one", guard);
      end else begin
        chk("to_delay", cyc - start_cyc, TO);
        chk("to_idle", busy, 0);
      end
      prev_to = 1;
      return;
    end
    prev_to = 0;

    k = 0; seen = 0; guard = 0; stall_left = 0; lat_d = 0; lat_l = 0;
    while (k < NN && guard < 600) begin
      @(posedge clk); #1;
      guard++;
      if (out_valid) begin
        if (!seen) begin
          seen  = 1;
          lat_d = out_data;
          lat_l = out_last;
          stall_left = (j.stall && (k % 2 == 1)) ? 5 : 0;
          if (j.abort) begin
            out_ready = 1'b0;
            reset     = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("abort_valid", out_valid, 0);
            chk("abort_busy", busy, 0);
            s0 = start_cnt;
            repeat (4) @(posedge clk);
            #1;
            chk("abort_no_start", start_cnt - s0, 0);
            chk("abort_idle_valid", out_valid, 0);
            return;
          end
        end else begin
          chk("hold_data", out_data, lat_d);
          chk("hold_last", out_last, lat_l);
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          chk("data", out_data, exp_c[k]);
          chk("last", out_last, (k == NN-1) ? 1 : 0);
          if (k == 0 && j.exp_c0 >= 0)    chk("data_first", out_data, j.exp_c0);
          if (k == NN-1 && j.exp_cl >= 0) chk("data_final", out_data, j.exp_cl);
          k++;
          seen = 0;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    if (k < NN) begin
      n_cmp++; n_bad++;
      $display("FAIL result_count: got %0d words, expected %0d", k, NN);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("busy_done", busy, 0);
    chk("valid_done", out_valid, 0);
    chk("start_count", start_cnt - s0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("no_extra_word", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t tbl[7];
    job_t rj;
    tbl[0] = '{0, 1, 1'b0, 1'b0, 1'b0, 1'b0,  3, 1'b0,      1,     16};
    tbl[1] = '{2, 2, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0, 260100, 260100};
    tbl[2] = '{3, 3, 1'b0, 1'b1, 1'b0, 1'b0,  7, 1'b0,     -1,     -1};
    tbl[3] = '{1, 1, 1'b1, 1'b0, 1'b1, 1'b0, TO, 1'b0,     90,    600};
    tbl[4] = '{3, 3, 1'b0, 1'b0, 1'b0, 1'b0,  0, 1'b1,     -1,     -1};
    tbl[5] = '{3, 3, 1'b1, 1'b1, 1'b0, 1'b0,  5, 1'b0,     -1,     -1};
    tbl[6] = '{0, 1, 1'b0, 1'b0, 1'b0, 1'b1,  2, 1'b0,     -1,     -1};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    spur_done = 1'b0; done_lat = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_start", mm_start, 0);
    chk("rst_raddr", res_raddr, 0);
    chk("rst_waddr", mem_waddr, 0);
    reset = 1'b0;
    #1;
    chk("idle_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) run_job(tbl[t]);
    run_job(tbl[0]);

    for (int r = 0; r < 4; r++) begin
      rj.a_kind   = int'($urandom_range(0, 3));
      rj.b_kind   = int'($urandom_range(1, 3));
      rj.gaps     = 1'($urandom_range(0, 1));
      rj.stall    = 1'($urandom_range(0, 1));
      rj.spur     = 1'($urandom_range(0, 1));
      rj.abort    = 1'b0;
      rj.done_lat = int'($urandom_range(1, TO));
      rj.exp_to   = 1'b0;
      rj.exp_c0   = -1;
      rj.exp_cl   = -1;
      run_job(rj);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/matmul_host_ctrl.md
Name: matmul_host_ctrl

Overview:
Host-side initiator and result reader for the 4x4 matrix multiplier (matrix_mult_simple_mem).
- Accepts a stream of operand words and writes matrices A and B into the multiplier's operand memory.
- Pulses start, waits for done with a timeout, then reads the N*N results and streams them out under valid/ready.
- Sits between the system data path and the multiplier core. It is the driver side of the clk/reset/start/done interface.

Parameters:
N, 4, matrix dimension (N x N)
DATA_W, 8, operand element width (unsigned)
ACC_W, 18, result element width; must be >= 2*DATA_W + clog2(N)
TIMEOUT, 1024, maximum cycles spent in WAIT before abort

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand word valid
in_ready  out  1  operand word accepted when in_valid && in_ready
in_data  in  DATA_W  operand word; A row-major then B row-major, 2*N*N words per job
mem_we  out  1  operand memory write enable
mem_waddr  out  clog2(2*N*N)  operand address; A at 0..N*N-1, B at N*N..2*N*N-1
mem_wdata  out  DATA_W  operand write data
mm_start  out  1  one-cycle start pulse to multiplier
mm_done  in  1  multiplier completion (level or pulse)
res_raddr  out  clog2(N*N)  result memory read address
res_rdata  in  ACC_W  result read data, valid one cycle after res_raddr
out_valid  out  1  result word valid
out_ready  in  1  downstream accept
out_data  out  ACC_W  result word, row-major C[i][j]
out_last  out  1  high with the final (N*N-1) result word
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (synchronous, active-high) state: IDLE.
- Reset values: all outputs 0; counters 0; timeout_err 0.
- Reset mid-job aborts immediately. No mm_start is issued afterwards, and out_valid is low on the cycle after reset is sampled.
- States: IDLE, LOAD, START, WAIT, RD_REQ, RD_CAP, SEND.
- IDLE: in_ready=1.
  - An accepted word writes address 0, clears timeout_err, sets wcnt=1 and moves to LOAD.
- LOAD: in_ready=1.
  - Each accepted word writes address wcnt, then wcnt increments.
  - Gaps in in_valid are allowed with no timeout.
  - The accept at wcnt==2*N*N-1 moves to START.
- Write port is combinational:
  - mem_we = in_valid && in_ready.
  - mem_waddr = wcnt (0 in IDLE).
  - mem_wdata = in_data.
- START: mm_start=1 for exactly one cycle. Clear the timer and move to WAIT.
- WAIT:
  - Timer increments each cycle.
  - mm_done=1 moves to RD_REQ with rcnt=0.
  - Otherwise, reaching timer==TIMEOUT-1 sets timeout_err=1 and moves to IDLE.
  - If mm_done and the timeout coincide, done wins.
  - mm_done is ignored in all other states.
- RD_REQ: drive res_raddr=rcnt, then move to RD_CAP.
- RD_CAP: register res_rdata into out_data, set out_valid=1 and out_last=(rcnt==N*N-1), then move to SEND.
- SEND: out_valid, out_data and out_last are held stable until out_ready.
  - On handshake, drop out_valid.
  - If rcnt==N*N-1, move to IDLE. Otherwise increment rcnt and move to RD_REQ.
- Result cadence: minimum 3 cycles per result, no reordering, exactly N*N words per job.
- in_ready=0 in all states except IDLE and LOAD.
- res_raddr holds its last value outside RD_REQ/RD_CAP.
- busy = (state != IDLE).

Test Plan:
1. Identity job: A=identity, B=1..16 row-major, out_ready=1 -> mm_start pulses once after the 32nd accept; outputs are 1..16 in order with out_last only on 16; busy falls to 0 after the last handshake.
2. Max-value job: all A and B = 255 -> all 16 outputs = 260100 (fits 18 bits); no wrap.
3. Backpressure: out_ready low for 5 cycles on every other word -> out_data/out_valid/out_last stable while stalled; no words lost or duplicated; still 16 words.
4. Input gaps: in_valid toggling 1/0 for the 32 words -> mem_waddr = 0..31 on the write cycles only; mem_we never asserted on gap cycles.
5. Timeout: TIMEOUT=16, mm_done held 0 -> timeout_err=1 sixteen cycles after the WAIT entry; state returns to IDLE with no out_valid. The next job's first accepted word clears timeout_err.
6. Spurious/abort: mm_done pulsed during LOAD -> ignored. Reset asserted during SEND -> out_valid=0 and busy=0 the next cycle, and a fresh full job then completes correctly.
